// File: rtl/vga2_pkg.sv
// Shared types and constants for the double-buffered, depth-composited scanline stage.
package vga2_pkg;

  localparam int VGA2_WIDTH = 640;
  localparam int VGA2_XW    = 10;
  localparam int VGA2_ZW    = 12;

  typedef struct packed {
    logic [VGA2_ZW-1:0] z;
    logic [23:0]        color;
  } scan_entry_t;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    RUN       = 2'd1,
    SWAP_WAIT = 2'd2
  } scan_state_t;

  // A cleared location: farthest depth, background colour.
  function automatic scan_entry_t bg_entry(input logic [23:0] color);
    scan_entry_t e;
    e.z     = {VGA2_ZW{1'b0}};
    e.color = color;
    return e;
  endfunction

endpackage

// File: rtl/vga2_linebuf_ram.sv
// One scanline buffer: simple dual-port RAM, one synchronous read port and one write port.
module vga2_linebuf_ram
  import vga2_pkg::*;
#(
  parameter int DEPTH = VGA2_WIDTH,
  parameter int AW    = VGA2_XW
) (
  input  logic        clock,
  input  logic        we,
  input  logic [AW-1:0] waddr,
  input  scan_entry_t wdata,
  input  logic        re,
  input  logic [AW-1:0] raddr,
  output scan_entry_t rdata
);

  scan_entry_t mem [DEPTH];

  // Write-first on a same-address collision, so a read never sees data one write stale.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/vga2_scanline.sv
// Depth-composites resolved pixels into one scanline buffer while the other is read out
// (and cleared behind the read) for display; buffers exchange on line_swap.
module vga2_scanline
  import vga2_pkg::*;
#(
  parameter int WIDTH = VGA2_WIDTH,
  parameter int XW    = VGA2_XW,
  parameter int ZW    = VGA2_ZW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pixel_valid,
  input  logic [XW-1:0] pixel_x,
  input  logic [ZW-1:0] pixel_z,
  input  logic [23:0]   pixel_color,
  input  logic [23:0]   bg_color,
  input  logic          line_swap,
  input  logic          disp_req,
  input  logic [XW-1:0] disp_x,
  output logic          disp_valid,
  output logic [23:0]   disp_color,
  output logic          ready,
  output logic          swap_done
);

  localparam logic [XW-1:0] LAST_X = XW'(WIDTH - 1);

  scan_state_t   state_r, state_s;
  logic          wsel_r, swap_pending_r;
  logic [XW-1:0] cnt_r;
  logic          ready_r, ready_s, swap_done_r, swap_done_s, init_we_s;

  logic          s1_valid_r, s2_valid_r, s2_we_r;
  logic [XW-1:0] s1_x_r, s2_x_r;
  logic [ZW-1:0] s1_z_r;
  logic [23:0]   s1_color_r;
  scan_entry_t   s2_entry_r, stored_s;

  logic          disp_valid_r, disp_hit_r, disp_buf_r, disp_buf_s;
  logic [XW-1:0] disp_x_r;
  logic [23:0]   disp_bg_r;

  logic          active_s, pix_acc_s, disp_rd_s, swap_fire_s, pass_s;
  logic [1:0]    ram_re_s, ram_we_s;
  logic [XW-1:0] ram_raddr_s [2];
  logic [XW-1:0] ram_waddr_s [2];
  scan_entry_t   ram_wdata_s [2];
  scan_entry_t   ram_rdata_s [2];

  assign active_s    = (state_r != INIT);
  assign pix_acc_s   = active_s && pixel_valid && (pixel_x <= LAST_X);
  assign disp_rd_s   = active_s && disp_req && (disp_x <= LAST_X);
  assign swap_fire_s = (state_r == SWAP_WAIT) && swap_pending_r &&
                       !s1_valid_r && !s2_valid_r && !pixel_valid;
  // In the swap cycle the display side is already the buffer selected after the toggle.
  assign disp_buf_s  = swap_fire_s ? wsel_r : ~wsel_r;
  assign stored_s    = (s2_we_r && (s2_x_r == s1_x_r)) ? s2_entry_r : ram_rdata_s[wsel_r];
  assign pass_s      = (s1_z_r >= stored_s.z);

  // State register and mode bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= INIT;
      cnt_r          <= {XW{1'b0}};
      wsel_r         <= 1'b0;
      swap_pending_r <= 1'b0;
      ready_r        <= 1'b0;
      swap_done_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= ((state_r == INIT) && (cnt_r != LAST_X)) ? cnt_r + XW'(1) : {XW{1'b0}};
      wsel_r         <= swap_fire_s ? ~wsel_r : wsel_r;
      if ((state_r == RUN) && line_swap) begin
        swap_pending_r <= 1'b1;
      end else if (swap_fire_s) begin
        swap_pending_r <= 1'b0;
      end
      ready_r        <= ready_s;
      swap_done_r    <= swap_done_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT:      if (cnt_r == LAST_X) state_s = RUN;       else state_s = INIT;
      RUN:       if (line_swap)       state_s = SWAP_WAIT; else state_s = RUN;
      SWAP_WAIT: if (swap_fire_s)     state_s = RUN;       else state_s = SWAP_WAIT;
      default:   state_s = INIT;
    endcase
  end

  // FSM outputs; ready and swap_done are registered from these.
  always_comb begin
    init_we_s   = (state_r == INIT);
    ready_s     = (state_s == RUN);
    swap_done_s = swap_fire_s;
  end

  // Pixel pipeline: S1 holds the accepted pixel during the RAM read, S2 holds the compare result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_x_r     <= {XW{1'b0}};
      s1_z_r     <= {ZW{1'b0}};
      s1_color_r <= 24'h000000;
      s2_valid_r <= 1'b0;
      s2_we_r    <= 1'b0;
      s2_x_r     <= {XW{1'b0}};
      s2_entry_r <= bg_entry(24'h000000);
    end else begin
      s1_valid_r <= pix_acc_s;
      if (pix_acc_s) begin
        s1_x_r     <= pixel_x;
        s1_z_r     <= pixel_z;
        s1_color_r <= pixel_color;
      end
      s2_valid_r <= s1_valid_r;
      s2_we_r    <= s1_valid_r && pass_s;
      if (s1_valid_r) begin
        s2_x_r           <= s1_x_r;
        s2_entry_r.z     <= s1_z_r;
        s2_entry_r.color <= s1_color_r;
      end
    end
  end

  // Display read tracking; the following cycle presents the data and clears the location.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_valid_r <= 1'b0;
      disp_hit_r   <= 1'b0;
      disp_buf_r   <= 1'b0;
      disp_x_r     <= {XW{1'b0}};
      disp_bg_r    <= 24'h000000;
    end else begin
      disp_valid_r <= active_s && disp_req;
      disp_hit_r   <= disp_rd_s;
      disp_buf_r   <= disp_buf_s;
      disp_x_r     <= disp_x;
      disp_bg_r    <= bg_color;
    end
  end

  // Port ownership per buffer: init clear, pixel side (wsel) or display side (!wsel).
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ram_re_s[i]    = 1'b0;
      ram_raddr_s[i] = pixel_x;
      ram_we_s[i]    = 1'b0;
      ram_waddr_s[i] = cnt_r;
      ram_wdata_s[i] = bg_entry(bg_color);
      if (disp_rd_s && (disp_buf_s == 1'(i))) begin
        ram_re_s[i]    = 1'b1;
        ram_raddr_s[i] = disp_x;
      end else if (pix_acc_s && (wsel_r == 1'(i))) begin
        ram_re_s[i]    = 1'b1;
        ram_raddr_s[i] = pixel_x;
      end else begin
        ram_re_s[i]    = 1'b0;
      end
      if (init_we_s) begin
        ram_we_s[i]    = 1'b1;
      end else if (s2_valid_r && s2_we_r && (wsel_r == 1'(i))) begin
        ram_we_s[i]    = 1'b1;
        ram_waddr_s[i] = s2_x_r;
        ram_wdata_s[i] = s2_entry_r;
      end else if (disp_valid_r && disp_hit_r && (disp_buf_r == 1'(i))) begin
        ram_we_s[i]    = 1'b1;
        ram_waddr_s[i] = disp_x_r;
      end else begin
        ram_we_s[i]    = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_buf
    vga2_linebuf_ram #(
      .DEPTH (WIDTH),
      .AW    (XW)
    ) u_ram (
      .clock (clock),
      .we    (ram_we_s[g]),
      .waddr (ram_waddr_s[g]),
      .wdata (ram_wdata_s[g]),
      .re    (ram_re_s[g]),
      .raddr (ram_raddr_s[g]),
      .rdata (ram_rdata_s[g])
    );
  end

  assign disp_valid = disp_valid_r;
  assign disp_color = !disp_valid_r ? 24'h000000 :
                      (disp_hit_r ? ram_rdata_s[disp_buf_r].color : disp_bg_r);
  assign ready      = ready_r;
  assign swap_done  = swap_done_r;

endmodule

// File: doc/vga2_scanline.md
Name: vga2_scanline

Overview:
- Downstream of the palette stage: takes resolved pixels (x, z, 24-bit colour) and depth-composites them into a double-buffered scanline RAM.
- One buffer is written by the sprite/pixel pipeline while the other is read out by the display timing stage.
- Readout clears each location behind it, so the buffer returns to background for its next line without a separate clear pass.

Parameters:
- WIDTH, 640, visible pixels per line; RAM depth per buffer.
- XW, 10, width of x coordinates.
- ZW, 12, width of depth values.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pixel_valid  in  1  pixel present this cycle
- pixel_x  in  XW  destination x
- pixel_z  in  ZW  pixel depth; larger value is in front
- pixel_color  in  24  RGB
- bg_color  in  24  background colour written by clears
- line_swap  in  1  single-cycle pulse at hblank: exchange buffers
- disp_req  in  1  display read request
- disp_x  in  XW  display read address
- disp_valid  out  1  disp_color valid
- disp_color  out  24  RGB to display
- ready  out  1  block accepting pixels and swaps
- swap_done  out  1  single-cycle pulse when the swap takes effect

Behaviour:
- Reset (async assert, sync release): state=INIT, wsel=0, init counter=0, disp_valid=0, disp_color=0, ready=0, swap_done=0, swap_pending=0, pipeline valids=0.
- Storage per buffer: {z[ZW], color[24]} x WIDTH. Each buffer is simple dual-port: 1 sync read, 1 write. Port ownership is muxed by wsel: buffer[wsel] belongs to the pixel side, buffer[!wsel] to the display side.
- FSM states: INIT, RUN, SWAP_WAIT.
- INIT:
  - Writes {0, bg_color} to address cnt in both buffers each cycle; cnt runs 0..WIDTH-1.
  - Exits to RUN after WIDTH cycles.
  - pixel_valid, disp_req and line_swap are ignored; disp_valid=0.
- ready=1 only in RUN.
- Pixel pipeline (RUN and SWAP_WAIT):
  - S1: on pixel_valid with pixel_x<WIDTH, issue read of buffer[wsel][x]; register x, z, colour.
  - S2: compare pixel z >= stored z (ZW-bit unsigned; equal z, later pixel wins). If it passes, write {z, colour}.
  - Pixels with x>=WIDTH are discarded at S1.
  - Throughput is 1 pixel/cycle. Write occurs 2 cycles after acceptance.
  - Hazard forwarding: when S1 and S2 hold the same x, S2's winning {z, colour} replaces the RAM read data for S1's compare. Back-to-back same-x pixels must composite exactly as if serialised.
- Display path:
  - disp_req with disp_x<WIDTH reads buffer[!wsel][disp_x].
  - disp_valid=1 and disp_color=stored colour the next cycle. The same cycle writes {0, bg_color} to that address (read-then-clear).
  - disp_req with disp_x>=WIDTH gives disp_valid=1 with disp_color=bg_color and no write.
- Swap:
  - line_swap in RUN sets swap_pending and moves to SWAP_WAIT.
  - In SWAP_WAIT, the swap executes when S1 and S2 are empty and no pixel_valid is present: wsel toggles, swap_done pulses, state returns to RUN.
  - Pixels arriving in SWAP_WAIT are still accepted into the old write buffer; upstream stops issuing after line_swap.
  - line_swap in INIT or SWAP_WAIT is ignored.
- Simultaneous events:
  - A display read and a pixel write never target the same buffer.
  - line_swap coinciding with pixel_valid: the pixel goes to the old buffer.
  - A disp_req in the swap cycle reads the buffer selected after the toggle.
- Reset mid-operation: immediate return to INIT. Both buffers are re-cleared and in-flight pixels are lost.

Decomposition:
- vga2_pkg holds VGA2_WIDTH, VGA2_ZW, a typedef scan_entry_t {z, color}, and typedef scan_state_t {INIT, RUN, SWAP_WAIT}.
- One sub-module, vga2_linebuf_ram: a simple dual-port RAM of scan_entry_t, instantiated twice; the top level owns all port muxing.

Test Plan:
- Reset release -> ready=0 for exactly 640 cycles. Then reading every x of either buffer after two swaps returns bg_color=0x102030.
- Write x=5 z=10 0xFF0000, then x=5 z=3 0x00FF00, swap, disp_req x=5 -> disp_color=0xFF0000. A second read of x=5 on the next line returns bg.
- Back-to-back same-x pixels x=7: z=4 0x0000AA, z=9 0x0000BB, z=9 0x0000CC -> display reads 0x0000CC (forwarding plus equal-z rule).
- line_swap with two pixels in flight -> swap_done delayed until S2 drains; both pixels appear on the display, none in the new write buffer.
- pixel_x=700 and disp_x=650 -> no RAM write; disp_valid=1 with bg_color.
- Assert reset during SWAP_WAIT -> outputs return to reset values asynchronously and INIT re-clears both buffers (640 cycles).
